// File: rtl/ds_group_arbiter_if.sv
// DataStream bundle for ds_group_arbiter: CHANNELS inbound streams merged onto
// one outbound stream tagged with channel index and end-of-group marker.
interface ds_group_arbiter_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic [CHANNELS*WIDTH-1:0] i_dat;
    logic [CHANNELS-1:0]       i_val;
    logic [CHANNELS-1:0]       i_rdy;
    logic [WIDTH-1:0]          o_dat;
    logic [CW-1:0]             o_chn;
    logic                      o_last;
    logic                      o_val;
    logic                      o_rdy;

    // Environment side: drives the sources and the sink ready.
    modport master (
        output i_dat, i_val, o_rdy,
        input  i_rdy, o_dat, o_chn, o_last, o_val
    );

    // Arbiter side.
    modport slave (
        input  i_dat, i_val, o_rdy,
        output i_rdy, o_dat, o_chn, o_last, o_val
    );
endinterface

// File: rtl/ds_group_arbiter.sv
// Round-robin arbiter holding each grant for GROUP accepted words so a
// downstream width expander always assembles a wide word from one source.
module ds_group_arbiter #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int GROUP    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    ds_group_arbiter_if.slave     bus
);
    localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNTW = (GROUP > 1) ? $clog2(GROUP) : 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   sel_r;
    logic [CNTW-1:0] cnt_r;
    logic [CW-1:0]   last_r;

    logic [CW-1:0]   scan_sel_s;
    logic            any_val_s;
    logic [CW-1:0]   sel_s;
    logic            val_s;
    logic            hs_s;
    logic            cnt_end_s;

    // Round-robin scan starting just after the channel that last completed a group.
    always_comb begin
        int   idx;
        logic found;
        scan_sel_s = '0;
        found      = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = (int'(last_r) + i) % CHANNELS;
            if (!found && bus.i_val[idx]) begin
                scan_sel_s = CW'(idx);
                found      = 1'b1;
            end else begin
                found      = found;
            end
        end
    end

    assign any_val_s = |bus.i_val;
    assign sel_s     = (state_r == LOCKED) ? sel_r : scan_sel_s;
    assign cnt_end_s = (cnt_r == CNTW'(GROUP - 1));

    // Transfers are suppressed while reset is held so no word is half-accepted.
    assign val_s     = !reset && bus.i_val[sel_s] && ((state_r == LOCKED) || any_val_s);
    assign hs_s      = val_s && bus.o_rdy;

    assign bus.o_val  = val_s;
    assign bus.o_dat  = bus.i_dat[int'(sel_s)*WIDTH +: WIDTH];
    assign bus.o_chn  = sel_s;
    assign bus.o_last = cnt_end_s;
    assign bus.i_rdy  = hs_s ? (CHANNELS'(1) << sel_s) : '0;

    // Grant FSM: lock on first valid so o_val/o_dat stay stable until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= UNLOCKED;
            sel_r   <= '0;
            cnt_r   <= '0;
            last_r  <= CW'(CHANNELS - 1);
        end else begin
            case (state_r)
                UNLOCKED: begin
                    if (!any_val_s) begin
                        state_r <= UNLOCKED;
                    end else if (!hs_s) begin
                        state_r <= LOCKED;
                        sel_r   <= sel_s;
                        cnt_r   <= '0;
                    end else if (GROUP == 1) begin
                        last_r  <= sel_s;
                    end else begin
                        state_r <= LOCKED;
                        sel_r   <= sel_s;
                        cnt_r   <= CNTW'(1);
                    end
                end
                LOCKED: begin
                    if (!hs_s) begin
                        state_r <= LOCKED;
                    end else if (cnt_end_s) begin
                        state_r <= UNLOCKED;
                        last_r  <= sel_r;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CNTW'(1);
                    end
                end
                default: begin
                    state_r <= UNLOCKED;
                    cnt_r   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ds_group_arbiter.sv
// Directed bench for ds_group_arbiter: GROUP=2 instance for most scenarios,
// GROUP=1 instance for the single-word-grant alternation case.
module tb_ds_group_arbiter;
    logic clk;
    logic reset;
    int   total_cnt;
    int   pass_cnt;
    int   fail_cnt;

    ds_group_arbiter_if #(.WIDTH(8), .CHANNELS(4)) ifa ();
    ds_group_arbiter_if #(.WIDTH(8), .CHANNELS(4)) ifb ();

    ds_group_arbiter #(.WIDTH(8), .CHANNELS(4), .GROUP(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    ds_group_arbiter #(.WIDTH(8), .CHANNELS(4), .GROUP(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [3:0] exp_chn [10];
        logic [3:0] alt_chn [4];
        exp_chn = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0, 4'd0};
        alt_chn = '{4'd0, 4'd2, 4'd0, 4'd2};
        total_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;

        reset     = 1'b1;
        ifa.i_dat = 32'hA4B3C2D1;
        ifa.i_val = 4'b0000;
        ifa.o_rdy = 1'b0;
        ifb.i_dat = 32'h44332211;
        ifb.i_val = 4'b0000;
        ifb.o_rdy = 1'b0;
        #7;

        // Reset-state outputs.
        check("rst_a_oval", ifa.o_val, 1'b0);
        check("rst_a_irdy", ifa.i_rdy, 4'b0000);
        check("rst_a_ochn", ifa.o_chn, 2'd0);
        check("rst_a_olast", ifa.o_last, 1'b0);
        check("rst_a_odat", ifa.o_dat, 8'hD1);
        check("rst_b_olast", ifb.o_last, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // GROUP=1: ch0 and ch2 alternate, o_last always high.
        ifb.i_val = 4'b0101;
        ifb.o_rdy = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("g1_chn", ifb.o_chn, alt_chn[i]);
            check("g1_last", ifb.o_last, 1'b1);
            check("g1_irdy", ifb.i_rdy, (alt_chn[i] == 4'd0) ? 4'b0001 : 4'b0100);
            cyc();
        end
        ifb.i_val = 4'b0000;

        // Single source ch2 sends A,B,C,D.
        ifa.o_rdy = 1'b1;
        ifa.i_val = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            ifa.i_dat[2*8 +: 8] = 8'hA0 + 8'(i);
            #1;
            check("ch2_dat", ifa.o_dat, 8'hA0 + 8'(i));
            check("ch2_chn", ifa.o_chn, 2'd2);
            check("ch2_last", ifa.o_last, (i % 2 == 1) ? 1'b1 : 1'b0);
            check("ch2_irdy", ifa.i_rdy, 4'b0100);
            cyc();
        end
        ifa.i_val = 4'b0000;

        // All channels valid: groups of two rotate 0,1,2,3,0 with no bubble.
        pulse_reset();
        ifa.i_dat = 32'h43424140;
        ifa.i_val = 4'b1111;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("rr_chn", ifa.o_chn, exp_chn[i]);
            check("rr_val", ifa.o_val, 1'b1);
            check("rr_dat", ifa.o_dat, 8'h40 + 8'(exp_chn[i]));
            cyc();
        end
        ifa.i_val = 4'b0000;

        // ch1 stalls mid-group; ch0 waits until ch1 finishes.
        pulse_reset();
        ifa.i_val = 4'b0010;
        #1;
        check("gap_first_chn", ifa.o_chn, 2'd1);
        check("gap_first_last", ifa.o_last, 1'b0);
        cyc();
        ifa.i_val = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("gap_oval", ifa.o_val, 1'b0);
            check("gap_irdy", ifa.i_rdy, 4'b0000);
            check("gap_chn", ifa.o_chn, 2'd1);
            cyc();
        end
        ifa.i_val = 4'b0011;
        #1;
        check("gap_end_chn", ifa.o_chn, 2'd1);
        check("gap_end_last", ifa.o_last, 1'b1);
        check("gap_end_irdy", ifa.i_rdy, 4'b0010);
        cyc();
        ifa.i_val = 4'b0001;
        #1;
        check("gap_ch0_chn", ifa.o_chn, 2'd0);
        check("gap_ch0_last", ifa.o_last, 1'b0);
        check("gap_ch0_irdy", ifa.i_rdy, 4'b0001);
        cyc();
        check("gap_ch0_last2", ifa.o_last, 1'b1);
        cyc();
        ifa.i_val = 4'b0000;

        // Backpressure: ch3 locked and stable while ch0 arrives.
        ifa.o_rdy = 1'b0;
        ifa.i_dat = 32'hD3000000 | 32'h000000C0;
        ifa.i_val = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_chn", ifa.o_chn, 2'd3);
            check("bp_dat", ifa.o_dat, 8'hD3);
            check("bp_val", ifa.o_val, 1'b1);
            check("bp_irdy", ifa.i_rdy, 4'b0000);
            cyc();
            ifa.i_val = 4'b1001;
        end
        ifa.o_rdy = 1'b1;
        #1;
        check("bp_rel_chn", ifa.o_chn, 2'd3);
        check("bp_rel_last", ifa.o_last, 1'b0);
        check("bp_rel_irdy", ifa.i_rdy, 4'b1000);
        cyc();
        check("bp_w2_chn", ifa.o_chn, 2'd3);
        check("bp_w2_last", ifa.o_last, 1'b1);
        cyc();
        check("bp_ch0_chn", ifa.o_chn, 2'd0);
        check("bp_ch0_dat", ifa.o_dat, 8'hC0);
        check("bp_ch0_irdy", ifa.i_rdy, 4'b0001);
        ifa.i_val = 4'b0000;

        // Reset mid-group of ch1; ch0 gets first grant afterwards.
        pulse_reset();
        ifa.i_val = 4'b0010;
        #1;
        check("mr_ch1_chn", ifa.o_chn, 2'd1);
        cyc();
        ifa.i_val = 4'b0011;
        reset = 1'b1;
        #1;
        check("mr_rst_irdy", ifa.i_rdy, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mr_post_chn", ifa.o_chn, 2'd0);
        check("mr_post_last", ifa.o_last, 1'b0);
        check("mr_post_irdy", ifa.i_rdy, 4'b0001);
        cyc();
        check("mr_post2_chn", ifa.o_chn, 2'd0);
        check("mr_post2_last", ifa.o_last, 1'b1);
        cyc();
        check("mr_next_chn", ifa.o_chn, 2'd1);
        check("mr_next_last", ifa.o_last, 1'b0);
        check("mr_next_irdy", ifa.i_rdy, 4'b0010);
        ifa.i_val = 4'b0000;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/ds_group_arbiter.md
# ds_group_arbiter

Round-robin arbiter that shares one DataStream sink, typically a `ds_width_expander` with FACTOR = GROUP, between CHANNELS inbound DataStream sources. A grant is held for exactly GROUP accepted words, so every wide output word the expander assembles comes from a single source. The channel index and an end-of-group marker travel with each word, so downstream logic can route or tag the assembled result.

## Interface
- WIDTH, 8: data width of each inbound stream and of the outbound stream.
- CHANNELS, 4: number of inbound sources (CHANNELS ≥ 2).
- GROUP, 2: words per grant (GROUP ≥ 1; set equal to the downstream expander FACTOR).
- CW (local): max($clog2(CHANNELS), 1), channel index width.
- reset  in  1  asynchronous, active-high reset.
- clk  in  1  single clock; all state updates on rising edge.
- i_dat  in  CHANNELS*WIDTH  inbound data; channel k occupies bits [k*WIDTH +: WIDTH].
- i_val  in  CHANNELS  per-channel valid.
- i_rdy  out  CHANNELS  per-channel ready.
- o_dat  out  WIDTH  outbound data.
- o_chn  out  CW  index of the channel currently driving o_dat.
- o_last  out  1  high on the GROUP-th word of a grant.
- o_val  out  1  outbound valid.
- o_rdy  in  1  outbound ready.

## Operation
- Handshake: a word transfers on any cycle where val & rdy are both high. Once o_val is asserted, it holds with o_dat/o_chn/o_last stable until accepted, as long as the selected source obeys the same rule.
- State registers:
  - lock_reg: grant held.
  - sel_reg[CW]: granted channel.
  - cnt_reg[max($clog2(GROUP),1)]: words accepted in the current group.
  - last_reg[CW]: last channel that completed a group.
- Effective selection sel:
  - If lock_reg = 1, sel = sel_reg.
  - If lock_reg = 0, sel = the first k with i_val[k] = 1, scanning last_reg+1, last_reg+2, … modulo CHANNELS.
  - If lock_reg = 0 and no i_val is set, sel = 0.
- Outputs:
  - o_dat = i_dat of channel sel; o_chn = sel.
  - o_val = i_val[sel] & (lock_reg | any i_val).
  - i_rdy[k] = o_rdy & o_val & (k == sel). Non-selected channels always see i_rdy = 0.
  - o_last = (cnt_reg == GROUP-1), or (GROUP == 1) when unlocked.
- FSM states: UNLOCKED (lock_reg = 0) and LOCKED (lock_reg = 1).
  - UNLOCKED, no valid: hold all state.
  - UNLOCKED, valid present, no handshake: go to LOCKED with sel_reg ← sel and cnt_reg ← 0. This freezes the choice so a higher-priority arrival cannot break o_val/o_dat stability.
  - UNLOCKED, handshake, GROUP = 1: stay UNLOCKED with last_reg ← sel.
  - UNLOCKED, handshake, GROUP > 1: go to LOCKED with sel_reg ← sel and cnt_reg ← 1.
  - LOCKED, handshake with cnt_reg == GROUP-1: go to UNLOCKED with last_reg ← sel_reg and cnt_reg ← 0.
  - LOCKED, handshake otherwise: cnt_reg ← cnt_reg + 1.
  - LOCKED, no handshake: hold. If the granted source drops i_val mid-group, the grant is kept and other channels wait.
- Fairness: after a group from channel k completes, channel k has the lowest priority. Each requesting channel is served within CHANNELS-1 groups of other channels.
- Reset, including mid-group: lock_reg = 0, cnt_reg = 0, sel_reg = 0, last_reg = CHANNELS-1, so channel 0 has first priority. A partially transferred group is abandoned, so the downstream expander must share the same reset.

## Timing
- Zero latency: combinational paths i_val/i_dat → o_val/o_dat and o_rdy → i_rdy. No data registers.
- Outputs right after reset:
  - o_val = 0, i_rdy = 0, o_chn = 0.
  - o_last = 1 if GROUP = 1, else 0.
  - o_dat = i_dat[WIDTH-1:0].
  - These values hold only while all i_val = 0.
- Back-to-back operation:
  - The first word of a new grant can transfer in the same cycle the previous group's last word's successor arbitration occurs, i.e. the cycle right after the completing handshake.
  - Full throughput is 1 word/clock with no bubble between groups.
- Wrap-around: the round-robin scan and the cnt_reg compare are modulo CHANNELS and GROUP respectively. cnt_reg never exceeds GROUP-1.

## Test plan
- Single source, CHANNELS=4, GROUP=2, o_rdy=1: ch2 sends A,B,C,D. Required: o_dat = A,B,C,D on consecutive cycles, o_chn=2, o_last = 0,1,0,1.
- All four channels valid continuously, GROUP=2, o_rdy=1. Required: o_chn sequence 0,0,1,1,2,2,3,3,0,0 with no idle cycles.
- ch1 granted and 1 word accepted; ch1 drops i_val for 3 cycles while ch0 is valid. Required: o_val=0 and i_rdy[0]=0 during the gap, then ch1 finishes its group (o_last=1) before ch0 is served.
- Backpressure: ch3 is valid while unlocked, o_rdy=0 for 4 cycles, then ch0 asserts valid. Required: o_chn stays 3 with o_dat stable; ch0 is served only after ch3's GROUP words.
- GROUP=1 with ch0 and ch2 valid. Required: o_chn alternates 0,2,0,2 and o_last is constantly 1.
- Assert reset after 1 of 2 words of a ch1 group, with ch0 and ch1 valid. Required: i_rdy=0 during reset; the first grant after release goes to ch0 with cnt restarting (o_last=0).
